// File: rtl/eth_tx_arb_pkg.sv
// Shared types for the TX arbiter: FSM state and the header sideband bundle
// forwarded alongside each frame.
package eth_tx_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int HDR_FIELD_WIDTH = 16;

  typedef struct packed {
    logic [HDR_FIELD_WIDTH-1:0] udp_length;
    logic [HDR_FIELD_WIDTH-1:0] udp_checksum;
    logic [HDR_FIELD_WIDTH-1:0] ip_length;
    logic [HDR_FIELD_WIDTH-1:0] ip_checksum;
  } hdr_fields_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker with optional strict priority for index 0.
// The scan starts one past last_grant and wraps modulo NUM_SRC.
module rr_arbiter #(
  parameter int NUM_SRC = 3,
  localparam int IDX_W = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] request,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               priority_en,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic [IDX_W-1:0]   cand_idx [NUM_SRC];
  logic [NUM_SRC-1:0] cand_req;

  // One extra bit of headroom keeps last_grant + offset from overflowing before the wrap.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum = {1'b0, last_grant} + (IDX_W+1)'(gi + 1);
    assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_SRC)) ?
                          IDX_W'(sum - (IDX_W+1)'(NUM_SRC)) : sum[IDX_W-1:0];
    assign cand_req[gi] = request[cand_idx[gi]];
  end

  always_comb begin
    grant   = '0;
    any_req = |request;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand_req[i]) grant = cand_idx[i];
    end
    if (priority_en && request[0]) grant = '0;
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular arbiter in front of the TX FIFO: one source owns the
// stream and header sideband from grant until its tlast beat is accepted.
module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_SRC       = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int SRC0_PRIORITY = 0,
  parameter int CNT_WIDTH     = 16,
  localparam int IDX_W = $clog2(NUM_SRC)
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_trdy,
  input  logic [NUM_SRC-1:0]            s_hdr_tvalid,
  input  logic [NUM_SRC*16-1:0]         s_udp_hdr_length,
  input  logic [NUM_SRC*16-1:0]         s_udp_hdr_checksum,
  input  logic [NUM_SRC*16-1:0]         s_ip_hdr_length,
  input  logic [NUM_SRC*16-1:0]         s_ip_hdr_checksum,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_trdy,
  output logic                          m_hdr_tvalid,
  output logic [15:0]                   m_udp_hdr_length,
  output logic [15:0]                   m_udp_hdr_checksum,
  output logic [15:0]                   m_ip_hdr_length,
  output logic [15:0]                   m_ip_hdr_checksum,
  output logic                          o_busy,
  output logic [IDX_W-1:0]              o_grant,
  output logic [CNT_WIDTH-1:0]          o_frame_count
);

  arb_state_t            state_reg;
  logic [IDX_W-1:0]      grant_reg;
  logic [IDX_W-1:0]      last_grant_reg;
  logic [CNT_WIDTH-1:0]  frame_count_reg;
  logic [IDX_W-1:0]      arb_grant;
  logic                  arb_any;
  logic                  busy;
  logic                  eof;
  logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
  hdr_fields_t           src_hdr  [NUM_SRC];
  hdr_fields_t           out_hdr;

  assign busy = (state_reg == ARB_BUSY);

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_data[gi]    = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign src_hdr[gi]     = {s_udp_hdr_length[gi*16 +: 16], s_udp_hdr_checksum[gi*16 +: 16],
                              s_ip_hdr_length[gi*16 +: 16],  s_ip_hdr_checksum[gi*16 +: 16]};
    assign s_axis_trdy[gi] = busy && (grant_reg == IDX_W'(gi)) && m_axis_trdy;
  end

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_rr (
    .request     (s_axis_tvalid),
    .last_grant  (last_grant_reg),
    .priority_en (SRC0_PRIORITY != 0),
    .grant       (arb_grant),
    .any_req     (arb_any)
  );

  // Pure pass-through while busy so the granted source sees FIFO backpressure directly.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_hdr_tvalid  = 1'b0;
    out_hdr       = '0;
    if (busy) begin
      m_axis_tdata  = src_data[grant_reg];
      m_axis_tvalid = s_axis_tvalid[grant_reg];
      m_axis_tlast  = s_axis_tlast[grant_reg];
      m_hdr_tvalid  = s_hdr_tvalid[grant_reg];
      out_hdr       = src_hdr[grant_reg];
    end
  end

  assign eof                = m_axis_tvalid && m_axis_trdy && m_axis_tlast;
  assign m_udp_hdr_length   = out_hdr.udp_length;
  assign m_udp_hdr_checksum = out_hdr.udp_checksum;
  assign m_ip_hdr_length    = out_hdr.ip_length;
  assign m_ip_hdr_checksum  = out_hdr.ip_checksum;

  // last_grant resets to the top index so source 0 wins the first round.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg       <= ARB_IDLE;
      grant_reg       <= '0;
      last_grant_reg  <= IDX_W'(NUM_SRC - 1);
      frame_count_reg <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (arb_any) begin
            grant_reg <= arb_grant;
            state_reg <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (eof) begin
            state_reg       <= ARB_IDLE;
            last_grant_reg  <= grant_reg;
            frame_count_reg <= frame_count_reg + CNT_WIDTH'(1);
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign o_busy        = busy;
  assign o_grant       = grant_reg;
  assign o_frame_count = frame_count_reg;

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Packet-granular arbiter that shares the single TX AXI-stream and header-sideband input of the Ethernet MAC/FIFO top level among NUM_SRC requesters (for example ARP responder, ICMP responder, UDP stack).
- Sits in the i_clk (100 MHz) domain, directly in front of the TX FIFO write port.
- Grants one source per frame, round-robin, with optional strict priority for source 0, and forwards that source's header values with the frame.

Parameters:
- NUM_SRC, 3, number of requesters (2..8).
- DATA_WIDTH, 8, AXI-stream data width.
- SRC0_PRIORITY, 0, 1 = source 0 wins every arbitration it requests; 0 = pure round-robin.
- CNT_WIDTH, 16, width of the per-arbiter frame counter.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  NUM_SRC*DATA_WIDTH  per-source data; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source last byte.
- s_axis_trdy  out  NUM_SRC  per-source ready.
- s_hdr_tvalid  in  NUM_SRC  per-source header-values-valid.
- s_udp_hdr_length, s_udp_hdr_checksum, s_ip_hdr_length, s_ip_hdr_checksum  in  NUM_SRC*16 each  per-source header fields.
- m_axis_tdata  out  DATA_WIDTH  to TX FIFO.
- m_axis_tvalid  out  1  to TX FIFO.
- m_axis_tlast  out  1  to TX FIFO.
- m_axis_trdy  in  1  TX FIFO ready.
- m_hdr_tvalid  out  1  to MAC header sideband.
- m_udp_hdr_length, m_udp_hdr_checksum, m_ip_hdr_length, m_ip_hdr_checksum  out  16 each  to MAC header sideband.
- o_busy  out  1  a frame is in progress.
- o_grant  out  $clog2(NUM_SRC)  index of the current or last granted source.
- o_frame_count  out  CNT_WIDTH  number of completed frames.

Behaviour:
- **Reset values.** State IDLE, o_grant=0, last_grant=NUM_SRC-1 (so source 0 wins the first round-robin), o_busy=0, o_frame_count=0. All s_axis_trdy bits, m_axis_tvalid, m_axis_tlast and m_hdr_tvalid are 0. Data and header outputs are 0 while IDLE.
- **IDLE state.**
  - The request vector is s_axis_tvalid.
  - If any bit is set, the winner is registered into o_grant, state goes to BUSY next cycle, and o_busy=1.
  - Arbitration latency is one cycle from first tvalid to the first possible transfer.
- **Winner selection.**
  - If SRC0_PRIORITY=1 and request[0]=1, the winner is 0.
  - Otherwise the winner is the first requesting index scanning last_grant+1, last_grant+2, … modulo NUM_SRC.
- **BUSY state.**
  - Combinational pass-through from granted source g: m_axis_tdata=s_axis_tdata[g], m_axis_tvalid=s_axis_tvalid[g], m_axis_tlast=s_axis_tlast[g].
  - s_axis_trdy[g]=m_axis_trdy; all other s_axis_trdy bits are 0.
  - Header fields are muxed from source g; m_hdr_tvalid=s_hdr_tvalid[g].
  - Zero added data latency.
- **End of frame.**
  - When m_axis_tvalid & m_axis_trdy & m_axis_tlast: state returns to IDLE, last_grant=g, o_frame_count increments (wraps at 2^CNT_WIDTH), o_busy=0 next cycle.
  - There is one mandatory idle cycle between frames; no same-cycle re-arbitration.
- **Grant stability.**
  - The grant never changes mid-frame.
  - tvalid deasserting mid-frame simply stalls the output; there is no timeout.
  - Requests from other sources are ignored until the frame ends.
- **Single-beat frame.** tvalid and tlast asserted on the same beat is legal and takes one BUSY cycle when trdy=1.
- **Backpressure.** m_axis_trdy=0 holds the transfer with no data loss; AXI rules are preserved because the path is pure pass-through.
- **Reset mid-frame.** Reset forces IDLE immediately; the partial frame is abandoned. Upstream sources and the FIFO are reset by the same reset.
- **o_grant** holds its value in IDLE until the next arbitration.

Decomposition:
- Package eth_tx_arb_pkg:
  - state enum {ARB_IDLE, ARB_BUSY};
  - typedef hdr_fields_t as a packed struct of the four 16-bit header fields.
- Sub-module rr_arbiter (request vector, last_grant, priority enable → grant index + any_req), combinational.
  - Reusable by the RX side for future multi-consumer fan-out.

Test Plan:
- **Single source.** Reset; source 1 sends a 64-byte frame with trdy=1 and header lengths 0x0030/0x0044. Required: o_grant=1 one cycle after tvalid; 64 bytes appear in order; header matches; o_frame_count=1; o_busy drops after tlast.
- **Round-robin.** Sources 0, 1 and 2 continuously request 4-byte frames. Required grant order 0,1,2,0,1,2 with exactly one idle cycle between frames; no beat from a non-granted source appears on the output.
- **Source 0 priority.** SRC0_PRIORITY=1; sources 0 and 2 both request continuously. Required: source 0 granted every frame and source 2 starved. Repeat with SRC0_PRIORITY=0 → strict 0,2 alternation.
- **Backpressure and stall.** Random m_axis_trdy (50%) and random gaps in the granted source's tvalid during a 100-byte frame. Required: output byte stream identical to input; grant unchanged until tlast; s_axis_trdy=0 on all other sources throughout.
- **Single-beat frames and counter wrap.** CNT_WIDTH=4; send 17 one-byte frames (tvalid and tlast together). Required: each frame completes in one BUSY cycle; o_frame_count reads 1 at the end.
- **Reset mid-frame.** Assert i_reset after byte 10 of 50 from source 2. Required: next cycle all outputs at reset values; after release with source 2 requesting, source 2 is granted because last_grant resets to NUM_SRC-1.
